// File: rtl/store_buffer.sv
// store_buffer: in-order store FIFO in front of a big-endian 16-bit data memory.
// Drains one store per granted cycle and forwards pending store bytes to loads.
module store_buffer #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   // core store port
   input  logic          st_valid,
   output logic          st_ready,
   input  logic [15:0]   st_addr,
   input  logic [15:0]   st_data,
   // core load port
   input  logic [15:0]   ld_addr,
   output logic [15:0]   ld_data,
   output logic [1:0]    ld_fwd,
   // memory load port
   output logic [15:0]   mem_ldaddr,
   input  logic [15:0]   mem_lddata,
   // memory write port
   input  logic          mem_grant,
   output logic          mem_wen,
   output logic [15:0]   mem_waddr,
   output logic [15:0]   mem_wdata,
   // status
   output logic          empty,
   output logic [CW-1:0] count
);

   localparam int unsigned AW = 16;
   localparam int unsigned DW = 16;
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } entry_t;

   entry_t          ent_q [DEPTH];
   entry_t          ent_d [DEPTH];
   logic [PW-1:0]   head_q, head_d;
   logic [PW-1:0]   tail_q, tail_d;
   logic [CW-1:0]   count_q, count_d;

   logic            full;
   logic            push;
   logic            pop;

   // Status and handshake derived from registered occupancy
   always_comb begin
      full     = (count_q == CW'(DEPTH));
      empty    = (count_q == '0);
      count    = count_q;
      st_ready = !full;
      push     = st_valid && !full;
      mem_wen  = !empty && mem_grant;
      pop      = mem_wen;
   end

   // Head entry always presented to the write port; gated by mem_wen
   always_comb begin
      mem_waddr = ent_q[head_q].addr;
      mem_wdata = ent_q[head_q].data;
   end

   // Next-state for pointers, occupancy and entry storage
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      ent_d   = ent_q;
      if (push) begin
         ent_d[tail_q].addr = st_addr;
         ent_d[tail_q].data = st_data;
         tail_d             = tail_q + PW'(1);
      end
      if (pop) begin
         head_d = head_q + PW'(1);
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            ent_q[i] <= '0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         ent_q   <= ent_d;
      end
   end

   // Load byte addresses: high result byte at ld_addr, low byte at ld_addr+1
   logic [AW-1:0] ld_b1_addr;
   logic [AW-1:0] ld_b0_addr;

   always_comb begin
      ld_b1_addr = ld_addr;
      ld_b0_addr = ld_addr + AW'(1);
      mem_ldaddr = ld_addr;
   end

   // Per-byte forwarding: walk oldest to youngest so the youngest match wins
   entry_t        fw_ent;
   logic [AW-1:0] fw_addr_nxt;
   logic [7:0]    fw_hi;
   logic [7:0]    fw_lo;
   logic [1:0]    fw_hit;

   always_comb begin
      fw_ent      = '0;
      fw_addr_nxt = '0;
      fw_hi       = mem_lddata[15:8];
      fw_lo       = mem_lddata[7:0];
      fw_hit      = 2'b00;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         if (CW'(k) < count_q) begin
            fw_ent      = ent_q[head_q + PW'(k)];
            fw_addr_nxt = fw_ent.addr + AW'(1);
            // high result byte
            if (fw_ent.addr == ld_b1_addr) begin
               fw_hi     = fw_ent.data[15:8];
               fw_hit[1] = 1'b1;
            end else if (fw_addr_nxt == ld_b1_addr) begin
               fw_hi     = fw_ent.data[7:0];
               fw_hit[1] = 1'b1;
            end
            // low result byte
            if (fw_ent.addr == ld_b0_addr) begin
               fw_lo     = fw_ent.data[15:8];
               fw_hit[0] = 1'b1;
            end else if (fw_addr_nxt == ld_b0_addr) begin
               fw_lo     = fw_ent.data[7:0];
               fw_hit[0] = 1'b1;
            end
         end
      end
   end

   // Merged load result
   always_comb begin
      ld_data = {fw_hi, fw_lo};
      ld_fwd  = fw_hit;
   end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: byte-map reference model, directed and random stimulus.
module tb_store_buffer;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW    = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          st_valid = 1'b0;
   logic          st_ready;
   logic [15:0]   st_addr = '0;
   logic [15:0]   st_data = '0;
   logic [15:0]   ld_addr = '0;
   logic [15:0]   ld_data;
   logic [1:0]    ld_fwd;
   logic [15:0]   mem_ldaddr;
   logic [15:0]   mem_lddata = '0;
   logic          mem_grant = 1'b0;
   logic          mem_wen;
   logic [15:0]   mem_waddr;
   logic [15:0]   mem_wdata;
   logic          empty;
   logic [CW-1:0] count;

   store_buffer #(.DEPTH(DEPTH), .CW(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
      .ld_addr(ld_addr), .ld_data(ld_data), .ld_fwd(ld_fwd),
      .mem_ldaddr(mem_ldaddr), .mem_lddata(mem_lddata),
      .mem_grant(mem_grant), .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .empty(empty), .count(count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] d;
   } st_t;

   st_t mq[$];     // pending stores in program order
   st_t exp_q[$];  // expected memory writes
   int  n_cmp = 0;
   int  n_err = 0;
   bit  started = 0;
   bit  m_push, m_pop;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference load: overlay pending stores onto a byte map in program order
   task automatic model_load(input logic [15:0] a, input logic [15:0] md,
                             output logic [15:0] d, output logic [1:0] f);
      logic [7:0]  bmap [logic [15:0]];
      logic [15:0] b1, b0, s;
      foreach (mq[i]) begin
         s = mq[i].a;
         bmap[s] = mq[i].d[15:8];
         s = s + 16'd1;
         bmap[s] = mq[i].d[7:0];
      end
      b1 = a;
      b0 = a + 16'd1;
      f  = 2'b00;
      d  = md;
      if (bmap.exists(b1)) begin d[15:8] = bmap[b1]; f[1] = 1'b1; end
      if (bmap.exists(b0)) begin d[7:0]  = bmap[b0]; f[0] = 1'b1; end
   endtask

   // Model state update at the active edge
   always @(posedge clk) begin
      if (!rst_n) begin
         mq.delete();
         exp_q.delete();
         started = 1;
      end else begin
         m_pop  = mem_grant && (mq.size() > 0);
         m_push = st_valid && (mq.size() < DEPTH);
         if (m_pop) void'(mq.pop_front());
         if (m_push) begin
            mq.push_back('{a: st_addr, d: st_data});
            exp_q.push_back('{a: st_addr, d: st_data});
         end
      end
   end

   // Monitor: compares outputs mid-cycle against the model and scoreboard
   always @(negedge clk) begin
      logic [15:0] md;
      logic [1:0]  mf;
      st_t         e;
      if (started) begin
         chk("count", 32'(count), 32'(mq.size()));
         chk("empty", 32'(empty), 32'(mq.size() == 0));
         chk("st_ready", 32'(st_ready), 32'(mq.size() < DEPTH));
         chk("mem_wen", 32'(mem_wen), 32'(mem_grant && (mq.size() > 0)));
         if (mem_grant && (mq.size() > 0)) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL write_order: got write %h with no expected write", mem_waddr);
            end else begin
               e = exp_q.pop_front();
               chk("mem_waddr", 32'(mem_waddr), 32'(e.a));
               chk("mem_wdata", 32'(mem_wdata), 32'(e.d));
            end
         end
         model_load(ld_addr, mem_lddata, md, mf);
         chk("ld_data", 32'(ld_data), 32'(md));
         chk("ld_fwd", 32'(ld_fwd), 32'(mf));
         chk("mem_ldaddr", 32'(mem_ldaddr), 32'(ld_addr));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_st(input logic [15:0] a, input logic [15:0] d);
      st_valid = 1'b1;
      st_addr  = a;
      st_data  = d;
      tick();
      st_valid = 1'b0;
   endtask

   task automatic drain();
      mem_grant = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      chk("drained_empty", 32'(empty), 32'd1);
   endtask

   task automatic load_chk(input string nm, input logic [15:0] a, input logic [15:0] md,
                           input logic [15:0] exp_d, input logic [1:0] exp_f);
      ld_addr    = a;
      mem_lddata = md;
      #1;
      chk({nm, "_data"}, 32'(ld_data), 32'(exp_d));
      chk({nm, "_fwd"}, 32'(ld_fwd), 32'(exp_f));
   endtask

   initial begin
      logic [15:0] pool [8] = '{16'h0100, 16'h0101, 16'h0102, 16'h0103,
                                16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
      // Reset then idle with grant high
      rst_n = 1'b0;
      mem_grant = 1'b1;
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      chk("reset_empty", 32'(empty), 32'd1);
      chk("reset_count", 32'(count), 32'd0);
      chk("reset_ready", 32'(st_ready), 32'd1);

      // Fill with grant low, fifth store ignored, then in-order drain
      mem_grant = 1'b0;
      push_st(16'h0010, 16'hAABB);
      push_st(16'h0020, 16'h1122);
      push_st(16'h0030, 16'h3344);
      push_st(16'h0040, 16'h5566);
      chk("full_count", 32'(count), 32'd4);
      chk("full_ready", 32'(st_ready), 32'd0);
      push_st(16'h0050, 16'h7777);
      chk("full_ignored", 32'(count), 32'd4);
      mem_grant = 1'b1;
      #1;
      chk("drain_first", 32'(mem_waddr), 32'h0010);
      drain();

      // Youngest store wins
      mem_grant = 1'b0;
      push_st(16'h0100, 16'h1234);
      push_st(16'h0100, 16'hABCD);
      load_chk("youngest", 16'h0100, 16'h0000, 16'hABCD, 2'b11);
      drain();

      // Partial overlap, each byte resolved independently
      mem_grant = 1'b0;
      push_st(16'h0200, 16'h1234);
      load_chk("ovl_hi", 16'h0201, 16'hEEFF, 16'h34FF, 2'b10);
      load_chk("ovl_lo", 16'h01FF, 16'h9988, 16'h9912, 2'b01);
      drain();

      // Address wrap
      mem_grant = 1'b0;
      push_st(16'hFFFF, 16'hCAFE);
      load_chk("wrap", 16'h0000, 16'h0011, 16'hFE11, 2'b10);
      mem_grant = 1'b1;
      #1;
      chk("wrap_wen", 32'(mem_wen), 32'd1);
      chk("wrap_waddr", 32'(mem_waddr), 32'hFFFF);
      chk("wrap_wdata", 32'(mem_wdata), 32'hCAFE);
      drain();

      // Full with simultaneous pop: no pass-through
      mem_grant = 1'b0;
      push_st(16'h0300, 16'h0102);
      push_st(16'h0302, 16'h0304);
      push_st(16'h0304, 16'h0506);
      push_st(16'h0306, 16'h0708);
      st_valid = 1'b1;
      st_addr  = 16'h0308;
      st_data  = 16'h090A;
      mem_grant = 1'b1;
      tick();
      chk("full_pop_count", 32'(count), 32'd3);
      tick();
      chk("next_push_count", 32'(count), 32'd3);
      st_valid = 1'b0;
      tick();
      mem_grant = 1'b0;
      chk("pre_reset_count", 32'(count), 32'd2);
      // Reset mid-drain discards pending stores
      rst_n = 1'b0;
      tick();
      chk("rst_mid_empty", 32'(empty), 32'd1);
      rst_n = 1'b1;
      mem_grant = 1'b1;
      tick();
      chk("rst_mid_nowen", 32'(mem_wen), 32'd0);
      tick();

      // Random traffic over a small overlapping address pool
      for (int i = 0; i < 3000; i++) begin
         rst_n      = ($urandom_range(0, 299) != 0);
         st_valid   = $urandom_range(0, 1)[0];
         st_addr    = pool[$urandom_range(0, 7)];
         st_data    = 16'($urandom);
         mem_grant  = ($urandom_range(0, 2) == 0);
         ld_addr    = ($urandom_range(0, 7) == 0) ? 16'($urandom) : pool[$urandom_range(0, 7)];
         mem_lddata = 16'($urandom);
         tick();
      end
      rst_n = 1'b1;
      st_valid = 1'b0;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Initiator-side front end for the byte-addressed, big-endian, 16-bit data memory: it drives the memory write port and the load-read port.
- Buffers core stores in an in-order FIFO and drains one store per granted cycle to the memory write port.
- Loads read memory combinationally, with byte-granular forwarding from pending stores.
- Sits between the execute/writeback stage and the memory; lets stores retire without waiting for the shared write port.

Parameters:
DEPTH, 4, number of store entries; power of two, >=2
CW, 3, count width = $clog2(DEPTH+1)

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  synchronous active-low reset
st_valid  in  1  core presents a store this cycle
st_ready  out  1  buffer can accept a store (= !full)
st_addr  in  16  store byte address
st_data  in  16  store data; [15:8] goes to st_addr, [7:0] to st_addr+1 (mod 2^16)
ld_addr  in  16  load byte address
ld_data  out  16  forwarded/merged load result, combinational
ld_fwd  out  2  per-byte forward flags: [1] = high byte forwarded, [0] = low byte forwarded
mem_ldaddr  out  16  to memory load port; equals ld_addr
mem_lddata  in  16  from memory load port, combinational read
mem_grant  in  1  write port granted this cycle
mem_wen  out  1  memory write enable
mem_waddr  out  16  head entry address
mem_wdata  out  16  head entry data
empty  out  1  no pending stores; used for fence/halt
count  out  CW  number of valid entries

Behaviour:
- State:
  - DEPTH entries {addr, data}.
  - head/tail pointers of log2(DEPTH) bits, wrapping modulo DEPTH.
  - count register.
- Reset (rst_n=0 at posedge):
  - head=tail=count=0; all pending stores are discarded, including mid-drain.
  - Entry contents are don't-care.
  - Outputs after reset: empty=1, st_ready=1, mem_wen=0, count=0.
- Push: st_valid && st_ready at posedge writes {st_addr, st_data} at tail; tail++.
  - st_valid while full: store is ignored; the producer must hold it.
- Drain (combinational):
  - mem_wen = !empty && mem_grant.
  - mem_waddr = head.addr; mem_wdata = head.data.
  - mem_waddr/mem_wdata are don't-care when empty.
  - Pop at the same posedge the memory commits the write (mem_wen=1): head++.
- Simultaneous push and pop: count unchanged.
  - Full with pop: st_ready stays 0 that cycle; there is no pass-through path.
  - Empty with push: the new entry is visible to drain and forwarding from the next cycle.
- Ordering: strict FIFO; memory sees stores in program order.
- Forwarding (fully combinational, same cycle):
  - Load bytes are B1 = ld_addr (result [15:8]) and B0 = ld_addr+1 mod 2^16 (result [7:0]).
  - A valid entry with address S covers byte S (its data[15:8]) and byte S+1 mod 2^16 (its data[7:0]).
  - For each load byte, the youngest valid covering entry supplies the byte; otherwise the byte comes from mem_lddata.
  - An entry being drained this cycle still forwards, because memory updates only at the edge.
  - A store pushed this cycle does not forward.
  - Each byte is resolved independently, so a mixed memory/buffer result is legal.
- Address wrap: 0xFFFF+1 = 0x0000, for both loads and stores.
- count/empty are registered-state derived; no X on any output after reset.

Test Plan:
1. Reset then idle, mem_grant=1 -> empty=1, count=0, mem_wen=0, st_ready=1 every cycle.
2. mem_grant=0; push stores to 0x0010/0xAABB, 0x0020/0x1122, 0x0030/0x3344, 0x0040/0x5566 -> count=4, st_ready=0; a fifth st_valid is ignored. Then raise mem_grant -> writes occur in order 0x0010, 0x0020, 0x0030, 0x0040, one per cycle; empty=1 after the 4th.
3. mem_grant=0; stores 0x0100/0x1234 then 0x0100/0xABCD; load 0x0100 with mem_lddata=0x0000 -> ld_data=0xABCD, ld_fwd=2'b11 (youngest wins).
4. Store 0x0200/0x1234 pending; load 0x0201 with mem_lddata=0xEEFF -> ld_data=0x34FF, ld_fwd=2'b10. Load 0x01FF with mem_lddata=0x9988 -> ld_data=0x9912, ld_fwd=2'b01.
5. Store 0xFFFF/0xCAFE; load 0x0000 with mem_lddata=0x0011 -> ld_data=0xFE11. When drained -> mem_waddr=0xFFFF, mem_wdata=0xCAFE.
6. Full buffer with mem_grant=1 and st_valid=1 -> pop occurs and count goes to 3; the push is accepted the next cycle. Assert rst_n=0 with 2 entries pending -> next cycle empty=1 and no further mem_wen.
